// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
// Optional single-cycle multiply path is selected by MULDIV_FAST_MUL_EN.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  // Value 7 is deliberately not enumerated; decoders treat it like MD_NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step.
// Sequencing (load/step) is owned by the ex_muldiv_unit FSM.
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] trial;

  // Partial remainder stays below the divisor, so the trial difference fits WIDTH bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvsr_q});
  assign trial   = shifted[WIDTH-1:0] - dvsr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q  <= ge ? trial : shifted[WIDTH-1:0];
      quo_q  <= {quo_q[WIDTH-2:0], ge};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning HI/LO; iterative shift-add multiply and restoring divide.
// Defining MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module ex_muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_start,
  input  logic [2:0]       EX_MDOp,
  input  logic [WIDTH-1:0] EX_rfOut1,
  input  logic [WIDTH-1:0] EX_rfOut2,
  input  logic             EX_cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  md_state_e        state, next_state;
  md_op_e           op;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             op_is_div, op_signed;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;

  logic             accept, load, step, commit;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op     = md_op_e'(EX_MDOp);
  assign accept = (state == IDLE) && EX_start && !EX_cancel;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && is_muldiv(op)) begin
          load = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
          next_state = is_div_op(op) ? CALC : FIX;
`else
          next_state = CALC;
`endif
        end
      end
      CALC: begin
        if (EX_cancel) begin
          next_state = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == '0) next_state = FIX;
        end
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step && op_is_div),
    .dividend  (mag(EX_rfOut1, is_signed_op(op))),
    .divisor   (mag(EX_rfOut2, is_signed_op(op))),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Shift-add step: conditionally add multiplicand into the high half, then shift right.
  assign add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

`ifdef MULDIV_FAST_MUL_EN
  assign prod_mag = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, prod[WIDTH-1:0]};
`else
  assign prod_mag = prod;
`endif

  assign prod_fix = (op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) ? -prod_mag : prod_mag;

  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (op_is_div) begin
      if (op_b == '0) begin
        res_hi = op_a;
        res_lo = '1;
      end else begin
        res_lo = (op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1])) ? -div_quo : div_quo;
        res_hi = (op_signed && op_a[WIDTH-1]) ? -div_rem : div_rem;
      end
    end
  end

  assign commit = (state == FIX) && !EX_cancel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_is_div <= 1'b0;
      op_signed <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      mcand     <= '0;
      prod      <= '0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != IDLE);

      if (load) begin
        op_is_div <= is_div_op(op);
        op_signed <= is_signed_op(op);
        op_a      <= EX_rfOut1;
        op_b      <= EX_rfOut2;
        mcand     <= mag(EX_rfOut1, is_signed_op(op));
        prod      <= {{WIDTH{1'b0}}, mag(EX_rfOut2, is_signed_op(op))};
        cnt       <= CW'(ITER - 1);
      end else if (step) begin
        cnt <= cnt - 1'b1;
        if (!op_is_div) prod <= {add_sum, prod[WIDTH-1:1]};
      end

      if (commit) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (accept && (op == MD_MTHI)) begin
        hi_q <= EX_rfOut1;
      end else if (accept && (op == MD_MTLO)) begin
        lo_q <= EX_rfOut1;
      end
    end
  end

  assign busy = busy_q;
  assign done = commit;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
